// File: rtl/key_pio_debounce.sv
`timescale 1ns/1ps
// Avalon-MM s1 input port for key/switch banks: two-flop synchroniser, per-channel
// debounce filter, per-bit rise/fall edge capture (write-1-to-clear) and a level irq.
module key_pio_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    typedef enum logic [2:0] {
        A_DATA     = 3'd0,
        A_RAW      = 3'd1,
        A_IRQ_MASK = 3'd2,
        A_EDGE_CAP = 3'd3,
        A_RISE_EN  = 3'd4,
        A_FALL_EN  = 3'd5,
        A_CTRL     = 3'd6,
        A_RSVD     = 3'd7
    } reg_addr_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic             deb_en_q, deb_en_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    reg_addr_e        addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr, rise, fall, ev;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign addr         = reg_addr_e'(address);
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive samples differ from it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!deb_en_q) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign rise = stable_q & ~stable_dly_q & rise_en_q;
    assign fall = ~stable_q & stable_dly_q & fall_en_q;
    assign ev   = rise | fall;
    assign clr  = (wr_en && addr == A_EDGE_CAP) ? wdata : '0;

    always_comb begin
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        deb_en_d   = deb_en_q;
        // New events are OR-ed in after the clear so a coincident event is never lost.
        edge_cap_d = (edge_cap_q & ~clr) | ev;
        if (wr_en) begin
            case (addr)
                A_IRQ_MASK: irq_mask_d = wdata;
                A_RISE_EN:  rise_en_d  = wdata;
                A_FALL_EN:  fall_en_d  = wdata;
                A_CTRL:     deb_en_d   = writedata[0];
                default:    ;
            endcase
        end
    end

    // Read data is registered every clock regardless of chipselect (fixed one-cycle latency).
    always_comb begin
        readdata_d = '0;
        case (addr)
            A_DATA:     readdata_d[WIDTH-1:0] = stable_q;
            A_RAW:      readdata_d[WIDTH-1:0] = s2_q;
            A_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            A_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
            A_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
            A_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
            A_CTRL:     readdata_d[0]         = deb_en_q;
            A_RSVD:     readdata_d            = '0;
            default:    readdata_d            = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            // NOTE: the counter array is reset explicitly; a reset mid-count must leave no partial count.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            edge_cap_q   <= '0;
            irq_mask_q   <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '1;
            deb_en_q     <= 1'b1;
            readdata_q   <= '0;
        end else begin
            s1_q         <= in_port;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            edge_cap_q   <= edge_cap_d;
            irq_mask_q   <= irq_mask_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            deb_en_q     <= deb_en_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_key_pio_debounce.sv
`timescale 1ns/1ps
// Directed bench for key_pio_debounce (WIDTH=4, DEBOUNCE_CYCLES=4): expectations are queued
// when stimulus is applied and popped against readdata/irq when the DUT responds.
module tb_key_pio_debounce;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         chipselect;
    logic [2:0]   address;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic         irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    key_pio_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .chipselect(chipselect),
        .address(address),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    task automatic push_exp(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty: observed %h with nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                mismatched++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        push_exp(tag, exp);
        tick();
        compare(readdata);
    endtask

    task automatic chk_rdata(input logic [31:0] exp, input string tag);
        push_exp(tag, exp);
        compare(readdata);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        push_exp(tag, {31'b0, exp});
        compare({31'b0, irq});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;
        in_port    = 4'hF;

        // Reset held two cycles with keys released
        ticks(2);
        chk_rdata(32'h0, "rst_readdata");
        chk_irq(1'b0, "rst_irq");
        reset_n = 1'b1;
        rd(3'd5, 32'hF, "rst_fall_en");
        rd(3'd6, 32'h1, "rst_ctrl");
        ticks(10);
        rd(3'd0, 32'hF, "rst_data_settled");
        rd(3'd3, 32'h0, "rst_no_spurious_cap");
        rd(3'd2, 32'h0, "rst_irq_mask");
        rd(3'd4, 32'h0, "rst_rise_en");
        rd(3'd7, 32'h0, "reserved_reads_zero");

        // Glitch of 3 cycles on bit0 must be filtered
        wr(3'd2, 32'h1);
        in_port = 4'hE;
        ticks(3);
        in_port = 4'hF;
        ticks(8);
        rd(3'd0, 32'hF, "glitch_data");
        rd(3'd3, 32'h0, "glitch_cap");
        chk_irq(1'b0, "glitch_irq");

        // Held press on bit0: stable at k+5, capture/irq at k+6
        address = 3'd0;
        in_port = 4'hE;
        ticks(6);
        chk_rdata(32'hF, "press_data_k5");
        chk_irq(1'b0, "press_irq_k5");
        tick();
        chk_rdata(32'hE, "press_data_k6");
        chk_irq(1'b1, "press_irq_k6");
        rd(3'd3, 32'h1, "press_cap");
        in_port = 4'hF;
        ticks(8);
        rd(3'd3, 32'h1, "release_no_rise_cap");
        wr(3'd3, 32'h1);
        chk_irq(1'b0, "w1c_irq_drop");

        // Bounce on bit1 then a held press
        in_port = 4'hD; ticks(2);
        in_port = 4'hF; ticks(2);
        in_port = 4'hD; ticks(2);
        in_port = 4'hF; ticks(2);
        rd(3'd3, 32'h0, "bounce_no_cap");
        address = 3'd0;
        in_port = 4'hD;
        ticks(6);
        chk_rdata(32'hF, "bounce_data_k5");
        tick();
        chk_rdata(32'hD, "bounce_data_k6");
        rd(3'd3, 32'h2, "bounce_single_cap");
        wr(3'd3, 32'h2);
        in_port = 4'hF;
        ticks(8);
        rd(3'd3, 32'h0, "bounce_cleared");

        // Edge modes: rise-only on bit2, then both edges on bit3
        wr(3'd4, 32'h4);
        wr(3'd5, 32'h0);
        in_port = 4'hB;
        ticks(8);
        rd(3'd3, 32'h0, "rise_only_press");
        in_port = 4'hF;
        ticks(8);
        rd(3'd3, 32'h4, "rise_only_release");
        wr(3'd3, 32'h4);
        wr(3'd4, 32'h8);
        wr(3'd5, 32'h8);
        in_port = 4'h7;
        ticks(8);
        rd(3'd3, 32'h8, "both_press");
        wr(3'd3, 32'h8);
        rd(3'd3, 32'h0, "both_cleared");
        in_port = 4'hF;
        ticks(8);
        rd(3'd3, 32'h8, "both_release");
        wr(3'd3, 32'h8);

        // W1C on a two-bit capture, then clear colliding with a new event
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h5);
        in_port = 4'hA;
        ticks(8);
        rd(3'd3, 32'h5, "multi_cap");
        chk_irq(1'b1, "multi_irq");
        wr(3'd3, 32'h1);
        rd(3'd3, 32'h4, "w1c_partial");
        chk_irq(1'b0, "w1c_partial_irq");
        wr(3'd3, 32'h4);
        wr(3'd4, 32'h4);
        rd(3'd3, 32'h0, "pre_collision");
        in_port = 4'hE;
        ticks(6);
        wr(3'd3, 32'h4);
        rd(3'd3, 32'h4, "collision_set_wins");
        wr(3'd2, 32'h4);
        chk_irq(1'b1, "mask_enable_irq");
        wr(3'd2, 32'h1);
        chk_irq(1'b0, "mask_disable_irq");
        wr(3'd3, 32'h4);
        in_port = 4'hF;
        ticks(8);
        rd(3'd3, 32'h0, "rise_bit0_disabled");

        // Debounce off: 1-cycle pulse passes straight through
        wr(3'd6, 32'h0);
        rd(3'd6, 32'h0, "ctrl_off");
        wr(3'd5, 32'h1);
        wr(3'd4, 32'h0);
        address = 3'd0;
        in_port = 4'hE;
        tick();
        in_port = 4'hF;
        ticks(2);
        chk_rdata(32'hF, "nodeb_data_k2");
        chk_irq(1'b0, "nodeb_irq_k2");
        tick();
        chk_rdata(32'hE, "nodeb_data_k3");
        chk_irq(1'b1, "nodeb_irq_k3");
        tick();
        chk_rdata(32'hF, "nodeb_data_k4");
        rd(3'd3, 32'h1, "nodeb_cap");

        // Reset in the middle of a bit1 count
        wr(3'd6, 32'h1);
        in_port = 4'hD;
        ticks(4);
        reset_n = 1'b0;
        in_port = 4'hF;
        address = 3'd0;
        tick();
        chk_rdata(32'h0, "midrst_readdata");
        chk_irq(1'b0, "midrst_irq");
        reset_n = 1'b1;
        ticks(6);
        chk_rdata(32'h0, "midrst_data_r6");
        tick();
        chk_rdata(32'hF, "midrst_data_r7");
        rd(3'd3, 32'h0, "midrst_cap");
        rd(3'd5, 32'hF, "midrst_fall_en");
        rd(3'd6, 32'h1, "midrst_ctrl");
        chk_irq(1'b0, "midrst_irq_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/key_pio_debounce.md
# key_pio_debounce

Parametrised Avalon-MM input port for push-button and switch banks, the successor to the fixed 4-bit key PIO. It adds a configurable channel count, a per-channel debounce filter and per-bit rising/falling edge selection. Edge-capture bits are write-1-to-clear, and capture always wins over a simultaneous clear. It sits on the Nios II data bus as an `s1` slave and drives one level interrupt.

## Interface
Parameters:
- `WIDTH`, default 4: number of input channels, 1..32.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a level is accepted, 1..2^CNT_W-1.
- `CNT_W`, default 16: width of each per-channel debounce counter.

Ports:
- `clk`, in, 1: single system clock; all logic on its rising edge.
- `reset_n`, in, 1: reset, synchronous and active-low; sampled on `clk` rising edge.
- `chipselect`, in, 1: Avalon slave select.
- `address`, in, 3: register word address.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data; bits above WIDTH ignored.
- `readdata`, out, 32: registered read data; bits above WIDTH read 0.
- `in_port`, in, WIDTH: asynchronous raw inputs (keys are active-low).
- `irq`, out, 1: level interrupt, `|(edge_capture & irq_mask)`.

## Operation
Register map (write = `chipselect && !write_n` at that address):
- 0 DATA, RO: debounced levels (`stable`).
- 1 RAW, RO: synchronised undebounced levels (`s2`).
- 2 IRQ_MASK, RW: reset 0.
- 3 EDGE_CAPTURE, read gives the capture bits; writing 1 to a bit clears it, writing 0 leaves it unchanged.
- 4 RISE_EN, RW: reset 0.
- 5 FALL_EN, RW: reset all ones, which preserves the legacy falling-edge (key press) behaviour.
- 6 CTRL, RW: bit0 DEBOUNCE_EN, reset 1. Other bits read 0.
- 7: reserved; reads 0, writes ignored.

Per channel i:
- Synchroniser: `s1 <= in_port`, `s2 <= s1`.
- Debounce, DEBOUNCE_EN=1:
  - If `s2[i] == stable[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i]+1`.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches `stable`. The counter restarts on every bounce back to the current level.
- DEBOUNCE_EN=0: `stable <= s2` every cycle and all counters are held at 0. Toggling the enable mid-count discards the partial count.
- Edge detect: `stable_d <= stable`.
  - `rise = stable & ~stable_d & RISE_EN`.
  - `fall = ~stable & stable_d & FALL_EN`.
  - `ev = rise | fall`.
- Capture, applied at the clock edge: `edge_capture <= (edge_capture & ~clr) | ev`, where `clr` is `writedata` on a write to address 3, otherwise 0. Set beats clear on the same bit in the same cycle, so no event is lost.
- Changing RISE_EN/FALL_EN affects future events only; already-captured bits stay set.
- Reset (synchronous, `reset_n==0` at an edge) clears:
  - `s1`, `s2`, `stable`, `stable_d`, all counters, `edge_capture`, `IRQ_MASK`, `RISE_EN`, and `readdata`.
  - It sets FALL_EN to all ones and DEBOUNCE_EN to 1.
  - `irq` is 0 after reset.
  - Released keys (high) later produce a 0→1 `stable` transition. With the default RISE_EN=0 this captures nothing (no spurious interrupt).
- Reset mid-debounce aborts the count; no partial state survives.

## Timing
- Read latency is 1 cycle: `readdata <= mux(address)` every clock, independent of `chipselect`, matching the existing PIO wait-state setting.
- Writes take effect at the edge where the strobe is sampled. A read of the same register on the next cycle returns the new value.
- Input changes before edge k, debounce on:
  - `s2` updates at edge k+1.
  - `stable` updates at edge k+1+DEBOUNCE_CYCLES.
  - `edge_capture` sets at edge k+2+DEBOUNCE_CYCLES.
  - `irq` rises combinationally after that edge.
- Debounce off: `stable` updates at k+2 and capture sets at k+3.
- `irq` falls combinationally after the edge that clears the last unmasked capture bit or its mask bit.
- Channels are independent; simultaneous events on several bits set all of them in the same cycle.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `in_port`=4'hF. Check `readdata`=0, `irq`=0, FALL_EN reads 0xF, CTRL reads 1. After 10 cycles DATA reads 0xF and EDGE_CAPTURE reads 0.
- Debounce filter (`DEBOUNCE_CYCLES`=4): with IRQ_MASK=1, drop `in_port[0]` for 3 cycles → DATA unchanged, no capture. Then hold it low 4+ cycles → DATA bit0=0 at edge k+5, capture bit0 at k+6, `irq`=1.
- Bounce: toggle bit1 low/high/low with 2-cycle gaps, then hold low → only one falling capture, and DATA changes exactly 4 cycles after the last change on `s2`.
- Edge modes: RISE_EN=0x4, FALL_EN=0 → a press on bit2 gives no capture; a release sets capture=0x4. RISE_EN=FALL_EN=0x8 → press and release on bit3 each set bit3.
- W1C and collision: capture=0x5, write 0x1 to address 3 → reads 0x4. Write 0x4 in the same cycle a new bit2 event occurs → bit2 remains 1.
- Debounce off: write CTRL=0, pulse bit0 low for 1 cycle → DATA bit0 low for 1 cycle, capture set at k+3. Assert reset mid-count → counters and capture are cleared.
